// File: rtl/fetch_pkg.sv
// Shared opcodes, FSM encoding and opcode-legality helper for the instruction fetch/issue block.
package fetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {instr,pc} FIFO with flush; push and pop may coincide at any occupancy.
module fetch_fifo2 #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [31:0]       push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  output logic              valid,
  output logic [31:0]       head_instr,
  output logic [ADDR_W-1:0] head_pc,
  output logic [1:0]        count
);

  logic [31:0]       instr_q [2];
  logic [ADDR_W-1:0] pc_q    [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid      = (count_q != 2'd0);
  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue: PC, credit-based requests to a 1-cycle imem, 2-entry output queue.
// Optional macro FETCH_ILLEGAL_CHECK_EN: unsupported opcodes set sticky illegal and halt fetch.
//
// state | meaning
// IDLE  | after reset, waiting for start; redirect only reloads pc
// RUN   | issuing requests while queue credit allows
// HALT  | halt (or illegal) word seen; queue drains, no requests until redirect
module instr_fetch_issue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              illegal
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic              inflight_q;
  logic              squash_q;

  logic              fifo_valid;
  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;
  logic [1:0]        count;

  logic              resp_live, resp_halt, resp_bad, stop;
  logic              push, pop, flush, issue;
  logic [1:0]        occ_after;

  // A response is live unless it belongs to a pre-redirect request or collides with a redirect.
  assign resp_live = inflight_q & ~squash_q & ~redirect;
  assign resp_halt = resp_live & (imem_rdata[31:26] == OP_HALT);

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic illegal_q;
  assign resp_bad = resp_live & ~op_legal(imem_rdata[31:26]);
  assign illegal  = illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (resp_bad) illegal_q <= 1'b1;
  end
`else
  assign resp_bad = 1'b0;
  assign illegal  = 1'b0;
`endif

  assign stop  = resp_halt | resp_bad;
  assign flush = redirect & (state_q != IDLE);
  assign pop   = fifo_valid & out_ready & ~redirect;
  assign push  = resp_live & ~resp_halt;

  // Slots committed after this cycle: current entries minus pop plus the word landing now.
  assign occ_after = count - {1'b0, pop} + {1'b0, inflight_q};
  assign issue     = (state_q == RUN) & (occ_after < 2'd2) & ~stop;

  assign imem_req  = issue;
  assign imem_addr = issue ? pc_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!redirect && stop) state_d = HALT;
      HALT:    if (redirect) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      // A request issued in the redirect cycle targets the old path; drop its response.
      squash_q   <= redirect & issue;
      if (issue) resp_pc_q <= pc_q;
      if (redirect) pc_q <= redirect_pc;
      else if (issue) pc_q <= pc_q + ADDR_W'(4);
    end
  end

  fetch_fifo2 #(.ADDR_W(ADDR_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .push_instr (imem_rdata),
    .push_pc    (resp_pc_q),
    .valid      (fifo_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign out_valid  = fifo_valid;
  assign out_instr  = fifo_valid ? head_instr : '0;
  assign out_pc     = fifo_valid ? head_pc : '0;
  assign out_opcode = out_instr[31:26];
  assign out_funct  = out_instr[5:0];
  assign halted     = (state_q == HALT) & (count == 2'd0);

endmodule
